// File: rtl/mc_datapath_hs.sv
// mc_datapath_hs: multicycle MIPS datapath with register file and req/ready memory handshake
// Ports: clk/rst; controller controls (pc_write..pc_src); memory port mem_req/mem_we/mem_adr/
// mem_wdata out, mem_rdata/mem_ready in; stall (controller holds), bus_err (sticky timeout),
// zero (ALU result == 0), instruction (IR).
module mc_datapath_hs #(
  parameter int DW = 32,
  parameter int RA_W = 5,
  parameter int LINK_REG = 31,
  parameter logic [DW-1:0] RESET_PC = '0,
  parameter int MAX_WAIT = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pc_write,
  input  logic          pc_write_con,
  input  logic          IorD,
  input  logic          mem_rd,
  input  logic          mem_wr,
  input  logic          ir_write,
  input  logic [1:0]    reg_dst,
  input  logic [1:0]    reg_wr_dst,
  input  logic          reg_write,
  input  logic          alu_src_A,
  input  logic [1:0]    alu_src_B,
  input  logic [2:0]    alu_op,
  input  logic [1:0]    pc_src,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          mem_req,
  output logic          mem_we,
  output logic [DW-1:0] mem_adr,
  output logic [DW-1:0] mem_wdata,
  output logic          stall,
  output logic          bus_err,
  output logic          zero,
  output logic [DW-1:0] instruction
);
  typedef enum logic [1:0] {IDLE, WAIT, ERR} state_t;
  localparam logic [7:0] MW = 8'(MAX_WAIT);
  state_t st, st_nx;
  logic [7:0] cnt, cnt_nx;
  logic [DW-1:0] pc, ir, mdr, a, b, alu_out, rd1, rd2, src_a, src_b, alu_res, sext, pc_nx, wdata;
  logic [DW-1:0] regs [2**RA_W];
  logic [RA_W-1:0] rs, rt, rd, widx;
  logic req, done, pc_load;
  assign req = mem_rd | mem_wr;
  // rst gates the handshake outputs so an aborted access drops its request at once
  always_comb begin
    mem_req = ~rst & (st == WAIT | (st == IDLE & req));
    stall = ~rst & (st == ERR | (mem_req & ~mem_ready));
    done = mem_req & mem_ready;
    st_nx = st == IDLE ? (req & ~mem_ready ? WAIT : IDLE) :
            st == WAIT ? (mem_ready ? IDLE : (cnt == MW ? ERR : WAIT)) : ERR;
    cnt_nx = st == IDLE ? (req & ~mem_ready ? 8'd1 : 8'd0) :
             (st == WAIT & ~mem_ready) ? cnt + 8'd1 : 8'd0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st <= IDLE;
      cnt <= '0;
    end else begin
      st <= st_nx;
      cnt <= cnt_nx;
    end
  end
  assign bus_err = st == ERR;
  assign rs = RA_W'(ir[25:21]);
  assign rt = RA_W'(ir[20:16]);
  assign rd = RA_W'(ir[15:11]);
  assign rd1 = regs[rs];
  assign rd2 = regs[rt];
  assign sext = {{(DW-16){ir[15]}}, ir[15:0]};
  assign src_a = alu_src_A ? a : pc;
  assign src_b = alu_src_B == 2'd0 ? b : alu_src_B == 2'd1 ? DW'(4) :
                 alu_src_B == 2'd2 ? sext : {sext[DW-3:0], 2'b00};
  always_comb begin
    case (alu_op)
      3'd0: alu_res = src_a + src_b;
      3'd1: alu_res = src_a - src_b;
      3'd2: alu_res = src_a & src_b;
      3'd3: alu_res = src_a | src_b;
      3'd4: alu_res = {{(DW-1){1'b0}}, $signed(src_a) < $signed(src_b)};
      3'd5: alu_res = ~(src_a | src_b);
      3'd6: alu_res = src_a ^ src_b;
      default: alu_res = {{(DW-1){1'b0}}, src_a < src_b};
    endcase
  end
  assign zero = alu_res == '0;
  assign pc_nx = pc_src == 2'd0 ? alu_res : pc_src == 2'd1 ? {pc[DW-1:28], ir[25:0], 2'b00} :
                 pc_src == 2'd2 ? alu_out : rd1;
  assign widx = reg_dst == 2'd1 ? rd : reg_dst == 2'd2 ? RA_W'(LINK_REG) : rt;
  assign wdata = reg_wr_dst == 2'd1 ? mdr : reg_wr_dst == 2'd2 ? pc : alu_out;
  assign pc_load = (pc_write | (pc_write_con & zero)) & ~stall;
  assign mem_we = mem_wr;
  assign mem_adr = IorD ? alu_out : pc;
  assign mem_wdata = b;
  assign instruction = ir;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
      ir <= '0;
      mdr <= '0;
      a <= '0;
      b <= '0;
      alu_out <= '0;
      for (int i = 0; i < 2**RA_W; i++) regs[i] <= '0;
    end else begin
      if (!stall) begin
        a <= rd1;
        b <= rd2;
        alu_out <= alu_res;
      end
      if (pc_load) pc <= pc_nx;
      // a completing write leaves MDR/IR alone; done already implies stall=0
      if (done & ~mem_wr) begin
        mdr <= mem_rdata;
        if (ir_write) ir <= mem_rdata;
      end
      if (reg_write & ~stall & widx != '0) regs[widx] <= wdata;
    end
  end
endmodule
